// File: rtl/fc_sync_mc.sv
// rtl/fc_sync_mc.sv - multi-lane X/W synchroniser with skid buffer, backpressure and vector-length checking
//
// Purpose:
//   Pops the X FIFO (activations plus vector tags) and the W FIFO (weights) in lockstep.
//   Each X word is paired with exactly one W word. The pair is then handed to the PE array
//   through a BUF_DEPTH-entry skid buffer. The buffer is made of the output register plus an
//   internal FIFO of BUF_DEPTH-1 entries.
//   The block also counts elements and vectors, flags vector-length mismatches and pulses
//   done once the final beat of the job is accepted.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   x_fifo_* / w_fifo_*                 FIFO status in, registered pop out, data in (1-cycle read latency)
//   pe_ready                            PE array accepts the presented beat
//   mat_vld, mat_x, mat_w, mat_begin,
//   mat_end, mat_end_last               registered beat to the PE array (held while stalled)
//   cfg_vec_len                         expected elements per vector, 0 disables checking
//   err_clr, err_len                    sticky length-error flag and its clear
//   vec_cnt, done                       vectors completed in this job, end-of-job pulse
module fc_sync_mc #(
  parameter int X_LANES   = 1,
  parameter int W_BYTES   = 64,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   x_fifo_empty,
  input  logic                   x_fifo_almost_empty,
  output logic                   x_fifo_rd_en,
  input  logic [X_LANES*9-1:0]   x_fifo_dout,
  input  logic                   x_fifo_dout_vec_begin,
  input  logic                   x_fifo_dout_vec_end,
  input  logic                   x_fifo_dout_last,
  input  logic                   w_fifo_empty,
  input  logic                   w_fifo_almost_empty,
  output logic                   w_fifo_rd_en,
  input  logic [W_BYTES*9-1:0]   w_fifo_dout,
  input  logic                   pe_ready,
  output logic                   mat_vld,
  output logic [X_LANES*9-1:0]   mat_x,
  output logic [W_BYTES*9-1:0]   mat_w,
  output logic                   mat_begin,
  output logic                   mat_end,
  output logic                   mat_end_last,
  input  logic [CNT_W-1:0]       cfg_vec_len,
  input  logic                   err_clr,
  output logic                   err_len,
  output logic [CNT_W-1:0]       vec_cnt,
  output logic                   done
);

  localparam int XW = X_LANES * 9;
  localparam int WW = W_BYTES * 9;
  localparam int EW = XW + 3 + WW;
  localparam int FD = BUF_DEPTH - 1;
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int NW = OW + 2;

  // Entry layout: {x, begin, end, last, w}
  localparam int B_BIT = WW + 2;
  localparam int E_BIT = WW + 1;
  localparam int L_BIT = WW;

  logic          rd_q, rd_d, cap_q;
  logic          xr, wr;
  logic [NW-1:0] need;

  logic [EW-1:0] mem_q [FD];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [OW-1:0] fcnt_q, fcnt_d;
  logic          out_vld_q, out_vld_d;
  logic [EW-1:0] out_q, out_d, cap_data;
  logic          push, pop, acc, out_free;

  logic [CNT_W-1:0] ecnt_q, ecnt_d, vcnt_q, vcnt_d, len_m1;
  logic             err_q, err_d, done_q, done_d, len_bad;

  // A FIFO with a pop already in flight must hold a second word before it is popped again.
  assign xr = ~x_fifo_empty & (~rd_q | ~x_fifo_almost_empty);
  assign wr = ~w_fifo_empty & (~rd_q | ~w_fifo_almost_empty);

  // Reserve a buffer slot at issue time: stored entries plus pops whose data is still on its way.
  assign need = NW'(fcnt_q) + NW'(out_vld_q) + NW'(rd_q) + NW'(cap_q) + NW'(1);
  assign rd_d = xr & wr & (need <= NW'(BUF_DEPTH));

  assign cap_data = {x_fifo_dout, x_fifo_dout_vec_begin, x_fifo_dout_vec_end, x_fifo_dout_last, w_fifo_dout};
  assign acc      = out_vld_q & pe_ready;
  assign out_free = ~out_vld_q | acc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
  endfunction

  // The output register is refilled from the internal FIFO first so order is kept.
  // Captured data goes straight to the output only when nothing older is waiting.
  always_comb begin
    out_vld_d = out_vld_q;
    out_d     = out_q;
    push      = 1'b0;
    pop       = 1'b0;
    if (out_free) begin
      if (fcnt_q != '0) begin
        out_vld_d = 1'b1;
        out_d     = mem_q[rp_q];
        pop       = 1'b1;
        push      = cap_q;
      end else if (cap_q) begin
        out_vld_d = 1'b1;
        out_d     = cap_data;
      end else begin
        out_vld_d = 1'b0;
        out_d     = '0;
      end
    end else begin
      push = cap_q;
    end
    wp_d   = push ? ptr_inc(wp_q) : wp_q;
    rp_d   = pop ? ptr_inc(rp_q) : rp_q;
    fcnt_d = fcnt_q + OW'(push) - OW'(pop);
  end

  assign len_m1  = cfg_vec_len - CNT_W'(1);
  assign len_bad = acc & (cfg_vec_len != '0) &
                   (out_q[E_BIT] ? (ecnt_q != len_m1) : (ecnt_q == len_m1));

  always_comb begin
    ecnt_d = ecnt_q;
    if (acc) ecnt_d = out_q[E_BIT] ? '0 : ecnt_q + CNT_W'(1);
    err_d  = err_clr ? 1'b0 : (err_q | len_bad);
    // The count of a finished job is dropped right after done, keeping any new vector end.
    if (done_q) vcnt_d = CNT_W'(acc & out_q[E_BIT]);
    else        vcnt_d = vcnt_q + CNT_W'(acc & out_q[E_BIT]);
    done_d = acc & out_q[L_BIT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q      <= 1'b0;
      cap_q     <= 1'b0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      fcnt_q    <= '0;
      ecnt_q    <= '0;
      vcnt_q    <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_q      <= rd_d;
      cap_q     <= rd_q;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      fcnt_q    <= fcnt_d;
      ecnt_q    <= ecnt_d;
      vcnt_q    <= vcnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  // Pure storage; validity is tracked by fcnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= cap_data;
  end

  always @(posedge clk) begin
    if (rst_n) assert (!(push && !pop && fcnt_q == OW'(FD)));
  end

  assign x_fifo_rd_en = rd_q;
  assign w_fifo_rd_en = rd_q;
  assign mat_vld      = out_vld_q;
  assign mat_x        = out_q[EW-1 -: XW];
  assign mat_begin    = out_q[B_BIT];
  assign mat_end      = out_q[E_BIT];
  assign mat_end_last = out_q[L_BIT];
  assign mat_w        = out_q[WW-1:0];
  assign err_len      = err_q;
  assign vec_cnt      = vcnt_q;
  assign done         = done_q;

endmodule

// File: tb/tb_fc_sync_mc.sv
// tb/tb_fc_sync_mc.sv - directed self-checking bench for fc_sync_mc
module tb_fc_sync_mc;
  localparam int XL = 2;
  localparam int WB = 4;
  localparam int BD = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic x_fifo_empty, x_fifo_almost_empty, x_fifo_rd_en;
  logic [XL*9-1:0] x_fifo_dout;
  logic x_fifo_dout_vec_begin, x_fifo_dout_vec_end, x_fifo_dout_last;
  logic w_fifo_empty, w_fifo_almost_empty, w_fifo_rd_en;
  logic [WB*9-1:0] w_fifo_dout;
  logic pe_ready = 1'b0;
  logic mat_vld, mat_begin, mat_end, mat_end_last;
  logic [XL*9-1:0] mat_x;
  logic [WB*9-1:0] mat_w;
  logic [CW-1:0] cfg_vec_len = '0;
  logic err_clr = 1'b0;
  logic err_len, done;
  logic [CW-1:0] vec_cnt;

  fc_sync_mc #(.X_LANES(XL), .W_BYTES(WB), .BUF_DEPTH(BD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .x_fifo_empty(x_fifo_empty), .x_fifo_almost_empty(x_fifo_almost_empty),
    .x_fifo_rd_en(x_fifo_rd_en), .x_fifo_dout(x_fifo_dout),
    .x_fifo_dout_vec_begin(x_fifo_dout_vec_begin), .x_fifo_dout_vec_end(x_fifo_dout_vec_end),
    .x_fifo_dout_last(x_fifo_dout_last),
    .w_fifo_empty(w_fifo_empty), .w_fifo_almost_empty(w_fifo_almost_empty),
    .w_fifo_rd_en(w_fifo_rd_en), .w_fifo_dout(w_fifo_dout),
    .pe_ready(pe_ready), .mat_vld(mat_vld), .mat_x(mat_x), .mat_w(mat_w),
    .mat_begin(mat_begin), .mat_end(mat_end), .mat_end_last(mat_end_last),
    .cfg_vec_len(cfg_vec_len), .err_clr(err_clr), .err_len(err_len),
    .vec_cnt(vec_cnt), .done(done)
  );

  // FIFO models: one-cycle read latency, entries {last, end, begin, x}
  logic [20:0] xmem [0:127];
  logic [35:0] wmem [0:127];
  int xwr = 0, xrd = 0, wwr = 0, wrd = 0;
  logic [20:0] xq = '0;
  logic [35:0] wq = '0;

  always @(posedge clk) begin
    if (x_fifo_rd_en) begin xq <= xmem[xrd % 128]; xrd <= xrd + 1; end
    if (w_fifo_rd_en) begin wq <= wmem[wrd % 128]; wrd <= wrd + 1; end
  end

  assign x_fifo_empty          = (xwr == xrd);
  assign x_fifo_almost_empty   = ((xwr - xrd) <= 1);
  assign w_fifo_empty          = (wwr == wrd);
  assign w_fifo_almost_empty   = ((wwr - wrd) <= 1);
  assign x_fifo_dout           = xq[17:0];
  assign x_fifo_dout_vec_begin = xq[18];
  assign x_fifo_dout_vec_end   = xq[19];
  assign x_fifo_dout_last      = xq[20];
  assign w_fifo_dout           = wq;

  int total = 0;
  int bad = 0;
  logic stall = 1'b0;
  logic [63:0] held;
  logic [17:0] acc_x [0:31];
  logic [35:0] acc_w [0:31];
  int acc_n = 0;

  function automatic logic [17:0] xv(input int k);
    return 18'(k * 37 + 5);
  endfunction

  function automatic logic [35:0] wv(input int k);
    return 36'(k * 1001 + 77);
  endfunction

  function automatic logic [63:0] snap();
    return {6'b0, mat_vld, mat_x, mat_w, mat_begin, mat_end, mat_end_last};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_x(input int k, input logic b, input logic e, input logic l);
    xmem[xwr % 128] = {l, e, b, xv(k)};
    xwr = xwr + 1;
  endtask

  task automatic push_w(input int k);
    wmem[wwr % 128] = wv(k);
    wwr = wwr + 1;
  endtask

  // One cycle: check hold after a stall, apply pe_ready, log the beat that will be accepted.
  task automatic cyc(input logic p);
    @(negedge clk);
    if (stall) chk("hold", snap(), held);
    pe_ready = p;
    if (mat_vld && p && acc_n < 32) begin
      acc_x[acc_n] = mat_x;
      acc_w[acc_n] = mat_w;
      acc_n++;
    end
    stall = mat_vld & ~p;
    held  = snap();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pe_ready = 1'b0;
    err_clr = 1'b0;
    cfg_vec_len = '0;
    stall = 1'b0;
    acc_n = 0;
    repeat (2) @(negedge clk);
    xwr = xrd;
    wwr = wrd;
    rst_n = 1'b1;
  endtask

  task automatic chk_zero();
    chk("rst_xrd", x_fifo_rd_en, 0);
    chk("rst_wrd", w_fifo_rd_en, 0);
    chk("rst_vld", mat_vld, 0);
    chk("rst_x", mat_x, 0);
    chk("rst_w", mat_w, 0);
    chk("rst_tags", {mat_begin, mat_end, mat_end_last}, 0);
    chk("rst_err", err_len, 0);
    chk("rst_vcnt", vec_cnt, 0);
    chk("rst_done", done, 0);
  endtask

  task automatic chk_beats(input int base, input int n);
    chk("beat_count", acc_n, n);
    for (int j = 0; j < n; j++) begin
      chk("beat_x", acc_x[j], xv(base + j));
      chk("beat_w", acc_w[j], wv(base + j));
    end
  endtask

  task automatic run_stream(input int base);
    cyc(1'b1);
    for (int j = 0; j < 8; j++) begin
      push_x(base + j, 1'b0, 1'b0, 1'b0);
      push_w(base + j);
    end
    for (int i = 1; i <= 11; i++) begin
      cyc(1'b1);
      chk("s_xrd", x_fifo_rd_en, (i <= 8));
      chk("s_wrd", w_fifo_rd_en, (i <= 8));
      chk("s_vld", mat_vld, (i >= 3 && i <= 10));
      if (i >= 3 && i <= 10) begin
        chk("s_x", mat_x, xv(base + i - 3));
        chk("s_w", mat_w, wv(base + i - 3));
      end else begin
        chk("s_x0", mat_x, 0);
      end
    end
    chk_beats(base, 8);
  endtask

  initial begin
    logic [3:0] pat;
    pat = 4'b1001;

    do_reset();
    chk_zero();

    // 1: streaming
    run_stream(0);

    // 2: backpressure with pe_ready pattern 1,0,0,1
    do_reset();
    cyc(1'b1);
    for (int j = 0; j < 8; j++) begin
      push_x(100 + j, 1'b0, 1'b0, 1'b0);
      push_w(100 + j);
    end
    for (int i = 1; i <= 40; i++) cyc(pat[i % 4]);
    chk_beats(100, 8);
    chk("bp_idle", mat_vld, 0);

    // 3: W FIFO empty while X holds data
    do_reset();
    cyc(1'b1);
    for (int j = 0; j < 4; j++) push_x(200 + j, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b1);
      chk("uf_rd", x_fifo_rd_en, 0);
      chk("uf_vld", mat_vld, 0);
      chk("uf_x", mat_x, 0);
    end
    for (int j = 0; j < 4; j++) push_w(200 + j);
    for (int i = 1; i <= 12; i++) cyc(1'b1);
    chk_beats(200, 4);

    // 4: vectors of length 4 then 3 against cfg_vec_len=4
    do_reset();
    cfg_vec_len = 16'd4;
    cyc(1'b1);
    for (int j = 0; j < 7; j++) begin
      push_x(300 + j, (j == 0 || j == 4), (j == 3 || j == 6), 1'b0);
      push_w(300 + j);
    end
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1);
      chk("len_err", err_len, (i >= 10));
    end
    err_clr = 1'b1;
    cyc(1'b1);
    err_clr = 1'b0;
    chk("len_clr", err_len, 0);
    chk("len_vcnt", vec_cnt, 2);
    chk_beats(300, 7);

    // 5: three vectors of two elements, final one tagged last
    do_reset();
    cfg_vec_len = 16'd2;
    cyc(1'b1);
    for (int j = 0; j < 6; j++) begin
      push_x(400 + j, (j % 2 == 0), (j % 2 == 1), (j == 5));
      push_w(400 + j);
    end
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1);
      chk("eoj_done", done, (i == 9));
      chk("eoj_last", mat_end_last, (i == 8));
      chk("eoj_vcnt", vec_cnt, (i >= 10) ? 0 : (i == 9) ? 3 : (i >= 7) ? 2 : (i >= 5) ? 1 : 0);
      chk("eoj_err", err_len, 0);
    end

    // 6: asynchronous reset with three entries buffered, then clean restart
    do_reset();
    cyc(1'b0);
    for (int j = 0; j < 8; j++) begin
      push_x(600 + j, 1'b0, 1'b0, 1'b0);
      push_w(600 + j);
    end
    for (int i = 1; i <= 5; i++) cyc(1'b0);
    chk("ar_vld", mat_vld, 1);
    chk("ar_x", mat_x, xv(600));
    rst_n = 1'b0;
    #1;
    chk_zero();
    do_reset();
    run_stream(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
